tx_module: RTL
==============

TX_MODULE -- requirements
Module: tx_module

Interface
REQ-001 Parameter BAUD_DIV, default 5208, clock cycles per serial bit (50 MHz / 9600 baud); legal range 2..65535.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 tx_en_sig  input  1  transmit request, sampled only in IDLE.
REQ-005 tx_data  input  8  byte to send, captured on the accepting cycle.
REQ-006 tx_pin_out  output  1  serial line; idles high.
REQ-007 tx_busy  output  1  high while a frame is in progress.
REQ-008 tx_done_sig  output  1  one-cycle pulse on frame completion.

Function
REQ-009 Frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1).
REQ-010 Every bit, including start and stop, SHALL hold tx_pin_out for exactly BAUD_DIV cycles; a full frame SHALL last 10*BAUD_DIV cycles.
REQ-011 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-012 IDLE -> START on the rising edge where tx_en_sig=1; tx_data SHALL be latched into an internal shift register on that edge.
REQ-013 tx_pin_out SHALL go low and tx_busy high on the cycle after acceptance (latency 1).
REQ-014 START -> DATA, DATA -> STOP and STOP -> IDLE SHALL occur when the baud counter reaches BAUD_DIV-1; the counter SHALL clear on every bit boundary and in IDLE.
REQ-015 In DATA, a 3-bit index SHALL count 0..7; DATA -> STOP SHALL occur only on the baud boundary with index=7.
REQ-016 tx_done_sig SHALL be high for exactly one cycle: the first IDLE cycle after STOP; tx_busy SHALL be low in that cycle.
REQ-017 A tx_en_sig asserted during that done cycle SHALL be accepted (back-to-back), giving exactly one idle-high cycle between frames.
REQ-018 tx_en_sig while tx_busy=1 SHALL be ignored and SHALL NOT alter the frame in progress; changes on tx_data after acceptance SHALL have no effect.
REQ-019 tx_pin_out, tx_busy and tx_done_sig SHALL be driven from flops (no combinational glitches on the line).
REQ-020 Baud counter width SHALL be $clog2(BAUD_DIV); no wrap beyond BAUD_DIV-1.

Reset
REQ-021 On rst_n=0, asynchronously: state IDLE, tx_pin_out=1, tx_busy=0, tx_done_sig=0, counters and shift register zero.
REQ-022 Reset mid-frame SHALL abort the frame, returning the line high immediately with no tx_done_sig pulse.
REQ-023 After rst_n deasserts, the first tx_en_sig SHALL be accepted on the first clk edge.

Structure
REQ-024 Shared package uart_pkg SHALL hold the FSM state enum (tx_state_t), frame constants (DATA_BITS=8, STOP_BITS=1) and the default BAUD_DIV; the future rx side reuses it.
REQ-025 One sub-module tx_baud_gen SHALL hold the baud counter and output a one-cycle bit_tick; tx_module holds FSM, shift register and bit index.
REQ-026 Total RTL SHALL stay within 120-400 lines.

Verification (BAUD_DIV=16 in bench)
REQ-027 tx_en_sig pulse, tx_data=8'h55 -> line low 16 cycles, then 1,0,1,0,1,0,1,0 each 16 cycles, high 16 cycles; tx_done_sig 1 cycle at cycle 161 after acceptance.
REQ-028 tx_data=8'hA3 then 8'h0F with tx_en_sig held high -> two frames, exactly one high cycle between stop bit and second start bit; decoded bytes A3, 0F.
REQ-029 tx_en_sig pulsed with tx_data=8'hFF at mid-frame of an 8'h00 frame -> 8'h00 frame unchanged, no second frame, tx_busy continuous for 160 cycles.
REQ-030 rst_n pulled low at cycle 70 of a frame -> tx_pin_out=1 and tx_busy=0 within the same cycle, no tx_done_sig; next request sends a clean frame.
REQ-031 Reset release then tx_en_sig on first edge with tx_data=8'h80 -> start bit on following cycle; only last data bit high.
REQ-032 Scoreboard: bench UART monitor sampling at bit centre matches every sent byte across 100 random bytes with random idle gaps 0..40 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg : state encoding and frame constants shared by the UART tx/rx sides
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int DATA_BITS        = 8;
    localparam int STOP_BITS        = 1;
    localparam int DEFAULT_BAUD_DIV = 5208;

endpackage

`default_nettype wire

// File: rtl/tx_baud_gen.sv
// ---------------------------------------------------------------------------
// tx_baud_gen : bit-period counter, bit_tick_o high on the last cycle of a bit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tx_baud_gen #(
    parameter int BAUD_DIV = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic bit_tick_o
);

    localparam int              CNT_W   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BAUD_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_max;

    assign at_max     = (cnt_q == CNT_MAX);
    assign bit_tick_o = en_i && at_max;

    // Held at zero while idle so the first bit of a frame gets a full period.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!en_i || at_max) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/tx_module.sv
// ---------------------------------------------------------------------------
// tx_module : 8N1 UART transmitter with registered line, busy and done outputs
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tx_module
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_en_sig,
    input  logic [7:0] tx_data,
    output logic       tx_pin_out,
    output logic       tx_busy,
    output logic       tx_done_sig
);

    localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    tx_state_t  state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] idx_q,   idx_d;
    logic       line_q,  line_d;
    logic       busy_q,  busy_d;
    logic       done_q,  done_d;
    logic       bit_tick;

    tx_baud_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (state_q != IDLE),
        .bit_tick_o (bit_tick)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        line_d  = line_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (tx_en_sig) begin
                    state_d = START;
                    shift_d = tx_data;
                    idx_d   = '0;
                    line_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                if (bit_tick) begin
                    state_d = DATA;
                    line_d  = shift_q[0];
                    shift_d = shift_q >> 1;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (idx_q == DATA_LAST) begin
                        state_d = STOP;
                        line_d  = 1'b1;
                        idx_d   = '0;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        line_d  = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end
            end
            STOP: begin
                // idx_q is reused to count stop bits
                if (bit_tick) begin
                    if (idx_q == STOP_LAST) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                line_d  = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            line_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            line_q  <= line_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx_pin_out  = line_q;
    assign tx_busy     = busy_q;
    assign tx_done_sig = done_q;

endmodule

`default_nettype wire
